// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with stall decode, flush and multi-cycle context loop
// Optional PIPE_STAGE_PERF_EN adds saturating bubble/hold cycle counters.
module pipe_stage_reg #(
  parameter int DATA_W    = 70,
  parameter int CTX_W     = 64,
  parameter int CNT_W     = 2,
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_payload,
  input  logic [CTX_W-1:0]   in_ctx,
  input  logic [CNT_W-1:0]   in_cnt,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_payload,
  output logic [CTX_W-1:0]   out_ctx,
  output logic [CNT_W-1:0]   out_cnt
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]        bubble_cnt,
  output logic [15:0]        hold_cnt
`endif
);

  generate
    if (STAGE_IDX < 0 || STAGE_IDX > STALL_W - 2) begin : g_bad_stage_idx
      $error("pipe_stage_reg: STAGE_IDX out of range for STALL_W");
    end
  endgenerate

  logic s_up;
  logic s_dn;
  logic is_bubble;
  logic stall_unused;

  assign s_up         = stall[STAGE_IDX];
  assign s_dn         = stall[STAGE_IDX+1];
  assign is_bubble    = s_up & ~s_dn;
  assign stall_unused = ^stall;

  // Any cycle with s_dn set (legal hold or illegal downstream-only stall) keeps state.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
      out_ctx     <= '0;
      out_cnt     <= '0;
    end else if (is_bubble) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
      out_ctx     <= in_ctx;
      out_cnt     <= in_cnt;
    end else if (!s_dn) begin
      out_valid   <= in_valid;
      out_payload <= in_valid ? in_payload : '0;
      out_ctx     <= '0;
      out_cnt     <= '0;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      hold_cnt   <= '0;
    end else if (!flush) begin
      if (is_bubble && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
      if (s_dn && hold_cnt != 16'hFFFF)
        hold_cnt <= hold_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - table-driven and randomized self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [69:0] in_payload = '0;
  logic [63:0] in_ctx = '0;
  logic [1:0]  in_cnt = '0;
  logic        out_valid;
  logic [69:0] out_payload;
  logic [63:0] out_ctx;
  logic [1:0]  out_cnt;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] bubble_cnt;
  logic [15:0] hold_cnt;
`endif

  pipe_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload), .in_ctx(in_ctx), .in_cnt(in_cnt),
    .out_valid(out_valid), .out_payload(out_payload), .out_ctx(out_ctx), .out_cnt(out_cnt)
`ifdef PIPE_STAGE_PERF_EN
    , .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [5:0]  stall;
    logic        flush;
    logic        in_valid;
    logic [69:0] in_payload;
    logic [63:0] in_ctx;
    logic [1:0]  in_cnt;
    logic        e_valid;
    logic [69:0] e_payload;
    logic [63:0] e_ctx;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [69:0] P_RST  = 70'h3F_DEAD_BEEF_0000_0001;
  localparam logic [63:0] C_A    = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] C_B    = 64'hCAFE_F00D_0BAD_1DEA;
  localparam logic [69:0] ONES   = {70{1'b1}};

  task automatic add(input logic r, input logic [5:0] s, input logic f, input logic v,
                     input logic [69:0] p, input logic [63:0] c, input logic [1:0] n,
                     input logic ev, input logic [69:0] ep, input logic [63:0] ec, input logic [1:0] en);
    vec_t t;
    t.rst_n = r; t.stall = s; t.flush = f; t.in_valid = v; t.in_payload = p; t.in_ctx = c; t.in_cnt = n;
    t.e_valid = ev; t.e_payload = ep; t.e_ctx = ec; t.e_cnt = en;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx, input logic [69:0] act, input logic [69:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n_vec++;
  endtask

  // Reference model state: what the register should hold after each edge.
  logic        m_valid;
  logic [69:0] m_payload;
  logic [63:0] m_ctx;
  logic [1:0]  m_cnt;
  int          m_bub;
  int          m_hold;

  task automatic model_update();
    bit up, dn;
    up = stall[3];
    dn = stall[4];
    if (!rst_n) begin
      m_valid = 0; m_payload = 0; m_ctx = 0; m_cnt = 0; m_bub = 0; m_hold = 0;
    end else if (flush) begin
      m_valid = 0; m_payload = 0; m_ctx = 0; m_cnt = 0;
    end else if (up && !dn) begin
      m_valid = 0; m_payload = 0; m_ctx = in_ctx; m_cnt = in_cnt;
      if (m_bub < 65535) m_bub++;
    end else if (dn) begin
      if (m_hold < 65535) m_hold++;
    end else begin
      m_valid = in_valid;
      m_payload = in_valid ? in_payload : 70'd0;
      m_ctx = 0; m_cnt = 0;
    end
  endtask

  initial begin
    logic [95:0] rp;
    // Directed sequence: reset, advance, bubble, hold, illegal stall, flush, invalid slot.
    add(0, 6'b000000, 0, 1, P_RST,  C_A, 2'd3,  0, 70'd0,  64'd0, 2'd0);
    add(0, 6'b000000, 0, 1, P_RST,  C_A, 2'd3,  0, 70'd0,  64'd0, 2'd0);
    add(1, 6'b000000, 0, 1, P_RST,  C_A, 2'd3,  1, P_RST,  64'd0, 2'd0);
    add(1, 6'b001000, 0, 1, 70'h9,  C_A, 2'd1,  0, 70'd0,  C_A,   2'd1);
    add(1, 6'b000000, 0, 1, 70'h5,  C_B, 2'd2,  1, 70'h5,  64'd0, 2'd0);
    add(1, 6'b011000, 0, 0, 70'h6,  C_A, 2'd1,  1, 70'h5,  64'd0, 2'd0);
    add(1, 6'b011000, 1'b0, 1, 70'h7, C_B, 2'd3, 1, 70'h5,  64'd0, 2'd0);
    add(1, 6'b111111, 0, 1, ONES,   C_A, 2'd2,  1, 70'h5,  64'd0, 2'd0);
    add(1, 6'b010000, 0, 1, 70'h8,  C_B, 2'd1,  1, 70'h5,  64'd0, 2'd0);
    add(1, 6'b001000, 0, 1, 70'hA,  C_B, 2'd2,  0, 70'd0,  C_B,   2'd2);
    add(1, 6'b011000, 0, 1, 70'hB,  C_A, 2'd3,  0, 70'd0,  C_B,   2'd2);
    add(1, 6'b011000, 1, 1, 70'hC,  C_A, 2'd3,  0, 70'd0,  64'd0, 2'd0);
    add(1, 6'b000000, 0, 0, ONES,   C_A, 2'd3,  0, 70'd0,  64'd0, 2'd0);
    add(1, 6'b000000, 0, 1, ONES,   C_A, 2'd3,  1, ONES,   64'd0, 2'd0);
    add(1, 6'b000000, 1, 1, 70'hD,  C_A, 2'd1,  0, 70'd0,  64'd0, 2'd0);
    add(1, 6'b001000, 0, 1, 70'hE,  C_A, 2'd1,  0, 70'd0,  C_A,   2'd1);
    add(0, 6'b001000, 0, 1, 70'hF,  C_B, 2'd2,  0, 70'd0,  64'd0, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; stall = vecs[i].stall; flush = vecs[i].flush;
      in_valid = vecs[i].in_valid; in_payload = vecs[i].in_payload;
      in_ctx = vecs[i].in_ctx; in_cnt = vecs[i].in_cnt;
      step();
      chk("tbl_valid",   i, 70'(out_valid),   70'(vecs[i].e_valid));
      chk("tbl_payload", i, out_payload,      vecs[i].e_payload);
      chk("tbl_ctx",     i, 70'(out_ctx),     70'(vecs[i].e_ctx));
      chk("tbl_cnt",     i, 70'(out_cnt),     70'(vecs[i].e_cnt));
    end

    // Randomized phase; the table ended in reset so the model starts cleared.
    m_valid = 0; m_payload = 0; m_ctx = 0; m_cnt = 0; m_bub = 0; m_hold = 0;
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      flush = ($urandom_range(0, 15) == 0);
      stall = 6'($urandom);
      in_valid = $urandom_range(0, 1) == 1;
      rp = {$urandom(), $urandom(), $urandom()};
      in_payload = rp[69:0];
      in_ctx = {$urandom(), $urandom()};
      in_cnt = 2'($urandom);
      model_update();
      step();
      chk("rnd_valid",   i, 70'(out_valid), 70'(m_valid));
      chk("rnd_payload", i, out_payload,    m_payload);
      chk("rnd_ctx",     i, 70'(out_ctx),   70'(m_ctx));
      chk("rnd_cnt",     i, 70'(out_cnt),   70'(m_cnt));
`ifdef PIPE_STAGE_PERF_EN
      chk("rnd_bubble_cnt", i, 70'(bubble_cnt), 70'(m_bub));
      chk("rnd_hold_cnt",   i, 70'(hold_cnt),   70'(m_hold));
`endif
    end

`ifdef PIPE_STAGE_PERF_EN
    flush = 0; rst_n = 0; stall = '0;
    step();
    rst_n = 1;
    stall = 6'b001000;
    for (int i = 0; i < 5; i++) step();
    stall = 6'b011000;
    for (int i = 0; i < 2; i++) step();
    stall = 6'b010000;
    step();
    chk("perf_bubble5", 0, 70'(bubble_cnt), 70'd5);
    chk("perf_hold3",   0, 70'(hold_cnt),   70'd3);
    stall = 6'b000000;
    flush = 1;
    step();
    flush = 0;
    step();
    chk("perf_keep_bubble", 0, 70'(bubble_cnt), 70'd5);
    chk("perf_keep_hold",   0, 70'(hold_cnt),   70'd3);
    stall = 6'b001000;
    for (int i = 0; i < 65529; i++) step();
    chk("perf_near_sat", 0, 70'(bubble_cnt), 70'hFFFE);
    for (int i = 0; i < 3; i++) step();
    chk("perf_sat", 0, 70'(bubble_cnt), 70'hFFFF);
    chk("perf_hold_unchanged", 0, 70'(hold_cnt), 70'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, the generic successor to the fixed EX/MEM latch. It carries an opaque payload bus plus a valid bit between two adjacent pipeline stages. It decodes its own slot of the controller's stall vector, inserts bubbles or holds, and supports a synchronous flush. It also preserves multi-cycle execution context (partial results and an iteration counter) across stall-induced bubbles. It is instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
DATA_W, 70, width of the payload bus (write enable, destination address, result, hi/lo, hilo enable, concatenated by the instantiating stage)
CTX_W, 64, width of the multi-cycle context bus (e.g. hilo temp)
CNT_W, 2, width of the multi-cycle iteration counter
STALL_W, 6, width of the controller stall vector
STAGE_IDX, 3, stall-vector bit owned by the upstream stage; downstream bit is STAGE_IDX+1; legal range 0..STALL_W-2

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
stall  input  STALL_W  controller stall vector, bit=1 means stage stalled
flush  input  1  synchronous squash of this register (exception/branch recovery)
in_valid  input  1  upstream stage holds a real instruction
in_payload  input  DATA_W  upstream stage outputs
in_ctx  input  CTX_W  multi-cycle context from upstream stage
in_cnt  input  CNT_W  multi-cycle iteration count from upstream stage
out_valid  output  1  registered valid
out_payload  output  DATA_W  registered payload
out_ctx  output  CTX_W  registered context, fed back to upstream stage
out_cnt  output  CNT_W  registered iteration count, fed back to upstream stage

Behaviour:
- Reset: rst_n sampled at clk edge. Reset is synchronous, active-low, on clock clk. While rst_n=0: out_valid=0, out_payload=0, out_ctx=0, out_cnt=0.
- Definitions: s_up = stall[STAGE_IDX]; s_dn = stall[STAGE_IDX+1].
- Per-edge priority, highest first: reset > flush > bubble > hold > advance.
- Flush (flush=1, any stall): out_valid=0, out_payload=0, out_ctx=0, out_cnt=0. This abandons any in-flight multi-cycle operation.
- Bubble (s_up=1, s_dn=0): out_valid=0, out_payload=0, out_ctx<=in_ctx, out_cnt<=in_cnt. The downstream stage sees a NOP while the upstream stage iterates.
- Hold (s_up=1, s_dn=1): all four outputs retain their previous value.
- Downstream-only stall (s_up=0, s_dn=1): controller-illegal. Treat it as hold; it must not corrupt state.
- Advance (s_up=0, s_dn=0):
  - out_valid<=in_valid.
  - out_payload<=in_payload when in_valid=1, else 0. An invalid slot never leaks write enables.
  - out_ctx<=0, out_cnt<=0, which releases the multi-cycle context.
- Latency: 1 cycle input to output when advancing. No combinational paths from input to output.
- Context loop: out_ctx/out_cnt change only on bubble, advance (clear), flush (clear) or reset (clear). Thus a multi-cycle op that stalls N cycles sees its context returned on each of those N cycles.
- Elaboration: if STAGE_IDX > STALL_W-2, elaboration must fail (generate-time error).

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined: adds output ports bubble_cnt[15:0] and hold_cnt[15:0], both reset to 0.
  - bubble_cnt increments on every bubble cycle.
  - hold_cnt increments on every hold cycle, including the illegal downstream-only case.
  - Both counters saturate at 16'hFFFF; flush and advance do not clear them. Only rst_n clears them.
- Undefined: ports absent, no counter logic, behaviour otherwise identical.

Test Plan:
- Reset/advance: hold rst_n=0 for 2 cycles with in_payload=70'h3F_DEAD_BEEF_0000_0001, then release with stall=0, in_valid=1. Required: all outputs 0 during reset; next edge out_valid=1 and out_payload=that value.
- Bubble with context: STAGE_IDX=3, stall=6'b001000, in_valid=1, in_ctx=64'h1234_5678_9ABC_DEF0, in_cnt=2'b01. Required: out_valid=0, out_payload=0, out_ctx=64'h1234_5678_9ABC_DEF0, out_cnt=1. Then set stall=0. Required: out_ctx=0, out_cnt=0, payload passes.
- Hold: after out_payload=70'h5, apply stall=6'b011000 for 3 cycles while changing inputs. Required: out_valid, out_payload, out_ctx, out_cnt unchanged for all 3 cycles.
- Flush priority: during bubble with out_cnt=2, assert flush=1 with stall=6'b011000. Required: next edge all outputs 0.
- Invalid slot: stall=0, in_valid=0, in_payload=all-ones. Required: out_valid=0, out_payload=0.
- Perf (PIPE_STAGE_PERF_EN): run 5 bubble cycles then 3 hold cycles. Required: bubble_cnt=5, hold_cnt=3. Force bubble_cnt=16'hFFFE plus 3 bubbles. Required: saturates at 16'hFFFF.
